// File: rtl/int_arbiter.sv
// Interrupt arbiter: latches rising edges of NUM_SRC lines, masks them and hands one winner
// to the CPU via a req/ack/reti handshake. Define INT_ROUND_ROBIN_EN for round-robin search.
module int_arbiter #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask_out,
  output logic [NUM_SRC-1:0] pending_out,
  output logic               cpu_int_req,
  input  logic               cpu_int_ack,
  output logic [ID_W-1:0]    int_id,
  input  logic               reti,
  output logic               in_service
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e            state_q, state_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic              req_q, req_d;
  logic              svc_q, svc_d;
  logic [IdxW-1:0]   id_q, id_d;
  logic [NUM_SRC-1:0] req_vec;
  logic [IdxW-1:0]   winner;
  logic              found;

`ifdef INT_ROUND_ROBIN_EN
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;

  // Search starts at rr_ptr and wraps back to source 0.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    req_vec = pending_q & mask_q;
    winner  = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req_vec[idx]) begin
        found  = 1'b1;
        winner = IdxW'(idx);
      end
    end
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    req_vec = pending_q & mask_q;
    winner  = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!found && req_vec[k]) begin
        found  = 1'b1;
        winner = IdxW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    svc_d     = svc_q;
    id_d      = id_q;
    pending_d = pending_q;
    mask_d    = mask_we ? mask_wdata : mask_q;
`ifdef INT_ROUND_ROBIN_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      StIdle: begin
        if (found) begin
          id_d    = winner;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (cpu_int_ack) begin
          pending_d[id_q] = 1'b0;
          req_d           = 1'b0;
          svc_d           = 1'b1;
          state_d         = StService;
`ifdef INT_ROUND_ROBIN_EN
          rr_ptr_d = (id_q == IdxW'(NUM_SRC - 1)) ? '0 : id_q + 1'b1;
`endif
        end
      end
      StService: begin
        if (reti) begin
          svc_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Applied after the ack clear so a same-cycle edge keeps the bit set.
    pending_d = pending_d | (irq_in & ~irq_prev_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      req_q      <= 1'b0;
      svc_q      <= 1'b0;
      id_q       <= '0;
`ifdef INT_ROUND_ROBIN_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      req_q      <= req_d;
      svc_q      <= svc_d;
      id_q       <= id_d;
`ifdef INT_ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign mask_out    = mask_q;
  assign pending_out = pending_q;
  assign cpu_int_req = req_q;
  assign int_id      = ID_W'(id_q);
  assign in_service  = svc_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: expected grant ids queue up as interrupts are driven
// and are popped when the DUT raises cpu_int_req.
module tb_int_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask_out;
  logic [7:0] pending_out;
  logic       cpu_int_req;
  logic       cpu_int_ack;
  logic [7:0] int_id;
  logic       reti;
  logic       in_service;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  logic req_seen = 1'b0;

  always #5 clk = ~clk;

  int_arbiter #(.NUM_SRC(8), .ID_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_out   (mask_out),
    .pending_out(pending_out),
    .cpu_int_req(cpu_int_req),
    .cpu_int_ack(cpu_int_ack),
    .int_id     (int_id),
    .reti       (reti),
    .in_service (in_service)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq_in = m;
    tick();
    irq_in = '0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!cpu_int_req && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {31'b0, cpu_int_req}, 32'd1);
  endtask

  task automatic do_ack();
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  // Scoreboard: each new request must match the oldest expected grant.
  always @(negedge clk) begin
    if (reset) begin
      req_seen <= 1'b0;
    end else begin
      if (cpu_int_req && !req_seen) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", exp_q.size(), 1);
        else check_eq("grant_id", {24'b0, int_id}, exp_q.pop_front());
      end
      req_seen <= cpu_int_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    cpu_int_ack = 1'b0; reti = 1'b0;
    tick(2);
    reset = 1'b0;
    tick();
    check_eq("rst_mask", mask_out, 8'hFF);
    check_eq("rst_pending", pending_out, 8'h00);
    check_eq("rst_req", cpu_int_req, 1'b0);
    check_eq("rst_id", int_id, 8'h00);
    check_eq("rst_insvc", in_service, 1'b0);

    // Single source with latency check.
    exp_q.push_back(3);
    irq_in = 8'h08;
    tick();
    check_eq("s1_pending", pending_out, 8'h08);
    check_eq("s1_req_early", cpu_int_req, 1'b0);
    irq_in = '0;
    tick();
    check_eq("s1_req", cpu_int_req, 1'b1);
    check_eq("s1_id", int_id, 8'd3);
    tick(2);
    check_eq("s1_req_hold", cpu_int_req, 1'b1);
    do_ack();
    check_eq("s1_ack_req", cpu_int_req, 1'b0);
    check_eq("s1_ack_pend", pending_out, 8'h00);
    check_eq("s1_ack_insvc", in_service, 1'b1);
    do_reti();
    check_eq("s1_reti_insvc", in_service, 1'b0);

    // Simultaneous sources 1 and 5.
`ifdef INT_ROUND_ROBIN_EN
    exp_q.push_back(5); exp_q.push_back(1);
`else
    exp_q.push_back(1); exp_q.push_back(5);
`endif
    pulse_irq(8'h22);
    wait_req("s2_req_a");
    do_ack();
`ifdef INT_ROUND_ROBIN_EN
    check_eq("s2_pend_left", pending_out, 8'h02);
`else
    check_eq("s2_pend_left", pending_out, 8'h20);
`endif
    tick();
    check_eq("s2_block", cpu_int_req, 1'b0);
    do_reti();
    wait_req("s2_req_b");
    do_ack();
    check_eq("s2_pend_none", pending_out, 8'h00);
    do_reti();

    // Masking, plus ack/reti ignored while idle.
    mask_we = 1'b1; mask_wdata = 8'hFB;
    tick();
    mask_we = 1'b0;
    check_eq("s3_mask", mask_out, 8'hFB);
    pulse_irq(8'h04);
    tick(3);
    check_eq("s3_pending", pending_out, 8'h04);
    check_eq("s3_no_req", cpu_int_req, 1'b0);
    do_ack();
    do_reti();
    check_eq("s3_ign_pend", pending_out, 8'h04);
    check_eq("s3_ign_insvc", in_service, 1'b0);
    exp_q.push_back(2);
    mask_we = 1'b1; mask_wdata = 8'hFF;
    tick();
    mask_we = 1'b0;
    check_eq("s3_req_wait", cpu_int_req, 1'b0);
    tick();
    check_eq("s3_req", cpu_int_req, 1'b1);
    check_eq("s3_id", int_id, 8'd2);
    do_ack();
    do_reti();

    // Set wins over ack clear.
    exp_q.push_back(4);
    pulse_irq(8'h10);
    wait_req("s4_req");
    exp_q.push_back(4);
    cpu_int_ack = 1'b1; irq_in = 8'h10;
    tick();
    cpu_int_ack = 1'b0; irq_in = '0;
    check_eq("s4_set_wins", pending_out, 8'h10);
    check_eq("s4_insvc", in_service, 1'b1);
    tick(3);
    check_eq("s4_block", cpu_int_req, 1'b0);
    do_reti();
    wait_req("s4_rereq");
    do_ack();

    // Edge during service is held until reti.
    pulse_irq(8'h01);
    tick(2);
    check_eq("s5_pending", pending_out, 8'h01);
    check_eq("s5_no_req", cpu_int_req, 1'b0);
    exp_q.push_back(0);
    do_reti();
    wait_req("s5_req");
    do_ack();
    do_reti();

    // Reset while a request is outstanding.
    mask_we = 1'b1; mask_wdata = 8'h8F;
    tick();
    mask_we = 1'b0;
    exp_q.push_back(7);
    pulse_irq(8'h80);
    wait_req("s6_req");
    pulse_irq(8'h01);
    check_eq("s6_pend_pre", pending_out, 8'h81);
    reset = 1'b1;
    tick();
    check_eq("s6_mask", mask_out, 8'hFF);
    check_eq("s6_pending", pending_out, 8'h00);
    check_eq("s6_req", cpu_int_req, 1'b0);
    check_eq("s6_id", int_id, 8'h00);
    check_eq("s6_insvc", in_service, 1'b0);
    reset = 1'b0;
    tick(3);
    check_eq("s6_req_after", cpu_int_req, 1'b0);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
